conv_stream_master: RTL and testbench

- Stream master and result collector for the X/F convolution core.
- The host preloads an X vector and an F vector into internal registers.
- On `start`, the block drives both vectors over independent valid/ready channels into the core's s_x/s_f slave ports.
- It then sinks the core's y stream into a result array the host reads back. It is the transmitting/receiving end facing the convolution unit's slave and master interfaces.

---
 rtl/conv_stream_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_conv_stream_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_master.sv
// conv_stream_master: stream master and result collector for the X/F convolution core.
//
// The host preloads an X vector and an F vector through the ld_* port. A start
// pulse in IDLE launches a job: both vectors are streamed over independent
// valid/ready channels (m_*_x, m_*_f) and the core's y stream is sunk into a
// result array the host reads back through rd_addr/rd_data.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ld_en/ld_sel/ld_addr/ld_data   host write into X (ld_sel=0) or F (ld_sel=1)
//   start                 launch a job (sampled in IDLE only)
//   busy, done            job in progress, one-cycle end-of-job pulse
//   m_valid_x/m_data_x/m_ready_x   X channel toward the core
//   m_valid_f/m_data_f/m_ready_f   F channel toward the core
//   s_valid_y/s_data_y/s_ready_y   y channel from the core
//   rd_addr/rd_data       combinational result read-back
//   throttle              present only with CONV_MASTER_THROTTLE_EN defined
//
// Optional feature macro: CONV_MASTER_THROTTLE_EN
//   Adds a throttle input. While high, no new valid is raised, a valid that is
//   already up is held until its handshake, and s_ready_y is forced low.
//
// X/F/result storage is deliberately not reset; a reset mid-job aborts the
// job and leaves any partial results in place.

module conv_stream_master #(
    parameter int unsigned DATA_WIDTH_X = 8,
    parameter int unsigned DATA_WIDTH_F = 8,
    parameter int unsigned X_SIZE       = 8,
    parameter int unsigned F_SIZE       = 4,
    parameter int unsigned ACC_SIZE     = 18,
    localparam int unsigned Y_SIZE      = X_SIZE - F_SIZE + 1,
    localparam int unsigned X_AW        = $clog2(X_SIZE),
    localparam int unsigned F_AW        = $clog2(F_SIZE),
    localparam int unsigned Y_AW        = $clog2(Y_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef CONV_MASTER_THROTTLE_EN
    input  logic                    throttle,
`endif
    input  logic                    ld_en,
    input  logic                    ld_sel,
    input  logic [X_AW-1:0]         ld_addr,
    input  logic [DATA_WIDTH_X-1:0] ld_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    m_valid_x,
    output logic [DATA_WIDTH_X-1:0] m_data_x,
    input  logic                    m_ready_x,
    output logic                    m_valid_f,
    output logic [DATA_WIDTH_F-1:0] m_data_f,
    input  logic                    m_ready_f,
    input  logic                    s_valid_y,
    input  logic [ACC_SIZE-1:0]     s_data_y,
    output logic                    s_ready_y,
    input  logic [Y_AW-1:0]         rd_addr,
    output logic [ACC_SIZE-1:0]     rd_data
);

    // Counters must be able to hold the terminal value (SIZE itself).
    localparam int unsigned XC_W = $clog2(X_SIZE + 1);
    localparam int unsigned FC_W = $clog2(F_SIZE + 1);
    localparam int unsigned YC_W = $clog2(Y_SIZE + 1);

    localparam logic [XC_W-1:0] X_END = XC_W'(X_SIZE);
    localparam logic [FC_W-1:0] F_END = FC_W'(F_SIZE);
    localparam logic [YC_W-1:0] Y_END = YC_W'(Y_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [XC_W-1:0]         x_cnt_q, x_cnt_d;
    logic [FC_W-1:0]         f_cnt_q, f_cnt_d;
    logic [YC_W-1:0]         y_cnt_q, y_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    m_valid_x_q, m_valid_x_d;
    logic [DATA_WIDTH_X-1:0] m_data_x_q, m_data_x_d;
    logic                    m_valid_f_q, m_valid_f_d;
    logic [DATA_WIDTH_F-1:0] m_data_f_q, m_data_f_d;
    logic                    s_ready_y_q, s_ready_y_d;

    logic [DATA_WIDTH_X-1:0] xreg_q   [X_SIZE];
    logic [DATA_WIDTH_F-1:0] freg_q   [F_SIZE];
    logic [ACC_SIZE-1:0]     result_q [Y_SIZE];

    logic                    x_we, f_we, y_we;
    logic                    x_fire_c, f_fire_c, y_fire_c;
    logic                    thr_c;
    logic                    x_addr_ok_c, f_addr_ok_c;
    logic [X_AW-1:0]         x_idx;
    logic [F_AW-1:0]         f_idx;
    logic [F_AW-1:0]         ld_faddr_c;

    // Throttle source; tied off when the feature is not built.
`ifdef CONV_MASTER_THROTTLE_EN
    assign thr_c = throttle;
`else
    assign thr_c = 1'b0;
`endif

    assign ld_faddr_c  = ld_addr[F_AW-1:0];
    assign x_addr_ok_c = (32'(ld_addr) < X_SIZE);
    assign f_addr_ok_c = (32'(ld_faddr_c) < F_SIZE);

    // Handshakes complete at the next posedge.
    assign x_fire_c = m_valid_x_q & m_ready_x;
    assign f_fire_c = m_valid_f_q & m_ready_f;
    assign y_fire_c = s_valid_y & s_ready_y;

    assign busy      = busy_q;
    assign done      = done_q;
    assign m_valid_x = m_valid_x_q;
    assign m_data_x  = m_data_x_q;
    assign m_valid_f = m_valid_f_q;
    assign m_data_f  = m_data_f_q;
    assign s_ready_y = s_ready_y_q & ~thr_c;

    // Host read-back, out-of-range indices read as zero.
    assign rd_data = (32'(rd_addr) < Y_SIZE) ? result_q[rd_addr] : '0;

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d     = state_q;
        x_cnt_d     = x_cnt_q;
        f_cnt_d     = f_cnt_q;
        y_cnt_d     = y_cnt_q;
        x_we        = 1'b0;
        f_we        = 1'b0;
        y_we        = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        m_valid_x_d = 1'b0;
        m_data_x_d  = '0;
        m_valid_f_d = 1'b0;
        m_data_f_d  = '0;
        s_ready_y_d = 1'b0;
        x_idx       = '0;
        f_idx       = '0;

        case (state_q)
            IDLE: begin
                if (ld_en) begin
                    if (ld_sel) begin
                        f_we = f_addr_ok_c;
                    end else begin
                        x_we = x_addr_ok_c;
                    end
                end
                if (start) begin
                    state_d = STREAM;
                    x_cnt_d = '0;
                    f_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            STREAM: begin
                if (x_fire_c) begin
                    x_cnt_d = x_cnt_q + XC_W'(1);
                end
                if (f_fire_c) begin
                    f_cnt_d = f_cnt_q + FC_W'(1);
                end
                if (y_fire_c) begin
                    y_we    = 1'b1;
                    y_cnt_d = y_cnt_q + YC_W'(1);
                end
                // Skip DRAIN when the last y lands together with the last X/F beat.
                if ((x_cnt_d == X_END) && (f_cnt_d == F_END)) begin
                    state_d = (y_cnt_d == Y_END) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (y_fire_c) begin
                    y_we    = 1'b1;
                    y_cnt_d = y_cnt_q + YC_W'(1);
                end
                if (y_cnt_d == Y_END) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        s_ready_y_d = ((state_d == STREAM) || (state_d == DRAIN)) && (y_cnt_d < Y_END);

        // X channel: a pending beat is always held; a new beat waits out throttle.
        x_idx = x_cnt_d[X_AW-1:0];
        if ((state_d == STREAM) && (x_cnt_d < X_END) &&
            (!thr_c || (m_valid_x_q && !x_fire_c))) begin
            m_valid_x_d = 1'b1;
            // Bypass a write landing on the same edge as start.
            m_data_x_d  = (x_we && (ld_addr == x_idx)) ? ld_data : xreg_q[x_idx];
        end

        // F channel, same rules as X.
        f_idx = f_cnt_d[F_AW-1:0];
        if ((state_d == STREAM) && (f_cnt_d < F_END) &&
            (!thr_c || (m_valid_f_q && !f_fire_c))) begin
            m_valid_f_d = 1'b1;
            m_data_f_d  = (f_we && (ld_faddr_c == f_idx)) ? ld_data[DATA_WIDTH_F-1:0]
                                                          : freg_q[f_idx];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_cnt_q     <= '0;
            f_cnt_q     <= '0;
            y_cnt_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            m_valid_x_q <= 1'b0;
            m_data_x_q  <= '0;
            m_valid_f_q <= 1'b0;
            m_data_f_q  <= '0;
            s_ready_y_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            f_cnt_q     <= f_cnt_d;
            y_cnt_q     <= y_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            m_valid_x_q <= m_valid_x_d;
            m_data_x_q  <= m_data_x_d;
            m_valid_f_q <= m_valid_f_d;
            m_data_f_q  <= m_data_f_d;
            s_ready_y_q <= s_ready_y_d;
        end
    end

    // Vector and result storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (x_we) begin
            xreg_q[ld_addr] <= ld_data;
        end
        if (f_we) begin
            freg_q[ld_faddr_c] <= ld_data[DATA_WIDTH_F-1:0];
        end
        if (y_we) begin
            result_q[y_cnt_q[Y_AW-1:0]] <= s_data_y;
        end
    end

endmodule

// File: tb/tb_conv_stream_master.sv
// Bench for conv_stream_master: the bench plays the convolution core and
// checks the streams and stored results against a vector-level model.

module tb_conv_stream_master;

    localparam int XS = 8;
    localparam int FS = 4;
    localparam int YS = XS - FS + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_en, ld_sel, start;
    logic [2:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        busy, done;
    logic        m_valid_x, m_ready_x, m_valid_f, m_ready_f;
    logic [7:0]  m_data_x, m_data_f;
    logic        s_valid_y = 1'b0;
    logic [17:0] s_data_y = '0;
    logic        s_ready_y;
    logic [2:0]  rd_addr;
    logic [17:0] rd_data;
`ifdef CONV_MASTER_THROTTLE_EN
    logic        throttle = 1'b0;
`endif

    conv_stream_master dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CONV_MASTER_THROTTLE_EN
        .throttle  (throttle),
`endif
        .ld_en     (ld_en),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .m_valid_x (m_valid_x),
        .m_data_x  (m_data_x),
        .m_ready_x (m_ready_x),
        .m_valid_f (m_valid_f),
        .m_data_f  (m_data_f),
        .m_ready_f (m_ready_f),
        .s_valid_y (s_valid_y),
        .s_data_y  (s_data_y),
        .s_ready_y (s_ready_y),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: vectors as the host loaded them, beats seen by the core.
    int mx [XS];
    int mf [FS];
    int rxx[XS];
    int rxf[FS];
    int xi = 0, fi = 0, yi = 0, cyc = 0, done_cnt = 0, extra_seen = 0;
    bit job_active = 1'b0;
    int rdy_mode = 0;
    bit y_gate = 1'b1;
    bit extra_y = 1'b0;
    logic pvx = 1'b0, prx = 1'b0, pvf = 1'b0, prf = 1'b0;
    logic [7:0] pdx = '0, pdf = '0;

    int lit1[YS] = '{10, 14, 18, 22, 26};
    int lit2[YS] = '{15, 19, 23, 27, 31};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Expected y from the host-loaded vectors.
    function automatic int exp_y(input int k);
        int s = 0;
        for (int j = 0; j < FS; j++) s += mx[k + j] * mf[j];
        return s;
    endfunction

    // What the core computes from the beats it actually received.
    function automatic int core_y(input int k);
        int s = 0;
        for (int j = 0; j < FS; j++) s += rxx[k + j] * rxf[j];
        return s;
    endfunction

    // Core emulation plus per-cycle compare, sampled 1 time unit before posedge.
    initial begin
        m_ready_x = 1'b0;
        m_ready_f = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rdy_mode == 1) begin
                m_ready_x = cyc[0];
                m_ready_f = (cyc % 3 == 0);
            end else begin
                m_ready_x = 1'b1;
                m_ready_f = 1'b1;
            end
            if (job_active && y_gate && yi < YS && fi == FS && xi >= yi + FS) begin
                s_valid_y = 1'b1;
                s_data_y  = 18'(core_y(yi));
            end else if (job_active && extra_y && yi >= YS) begin
                s_valid_y = 1'b1;
                s_data_y  = 18'h2AAAA;
            end else begin
                s_valid_y = 1'b0;
                s_data_y  = '0;
            end
            #4;
            if (!reset) begin
                job_active = 1'b0;
                xi = 0; fi = 0; yi = 0;
                pvx = 1'b0; pvf = 1'b0;
            end else begin
                if (start && !job_active) begin
                    job_active = 1'b1;
                    xi = 0; fi = 0; yi = 0;
                end
                if (pvx && !prx) begin
                    chk("x_valid_held", int'(m_valid_x), 1);
                    chk("x_data_held", int'(m_data_x), int'(pdx));
                end
                if (pvf && !prf) begin
                    chk("f_valid_held", int'(m_valid_f), 1);
                    chk("f_data_held", int'(m_data_f), int'(pdf));
                end
                if (m_valid_x && m_ready_x) begin
                    chk("x_beat_in_range", int'(xi < XS), 1);
                    if (xi < XS) begin
                        chk("x_beat_data", int'($signed(m_data_x)), mx[xi]);
                        rxx[xi] = int'($signed(m_data_x));
                    end
                    xi++;
                end
                if (m_valid_f && m_ready_f) begin
                    chk("f_beat_in_range", int'(fi < FS), 1);
                    if (fi < FS) begin
                        chk("f_beat_data", int'($signed(m_data_f)), mf[fi]);
                        rxf[fi] = int'($signed(m_data_f));
                    end
                    fi++;
                end
                if (s_valid_y && yi >= YS) begin
                    chk("y_extra_refused", int'(s_ready_y), 0);
                    extra_seen++;
                end else if (s_valid_y && s_ready_y) begin
                    yi++;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_x_beats", xi, XS);
                    chk("done_f_beats", fi, FS);
                    chk("done_y_beats", yi, YS);
                    chk("done_busy", int'(busy), 1);
                    job_active = 1'b0;
                end
                pvx = m_valid_x; prx = m_ready_x; pdx = m_data_x;
                pvf = m_valid_f; prf = m_ready_f; pdf = m_data_f;
            end
        end
    end

    task automatic load(input bit sel, input int addr, input int val);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = 3'(addr);
        ld_data = 8'(val);
        if (sel) mf[addr] = val;
        else     mx[addr] = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic start_job();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #4;
        chk("valid_x_rise", int'(m_valid_x), 1);
        chk("valid_f_rise", int'(m_valid_f), 1);
    endtask

    task automatic wait_done(input string nm);
        int n  = 0;
        int d0 = done_cnt;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk({nm, "_done_seen"}, int'(done), 1);
        @(negedge clk);
        #4;
        chk({nm, "_busy_fall"}, int'(busy), 0);
        chk({nm, "_done_single"}, int'(done), 0);
        chk({nm, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic check_results(input string nm, input int lit[YS]);
        for (int k = 0; k < YS; k++) begin
            rd_addr = 3'(k);
            #1;
            chk({nm, "_y_model"}, int'($signed(rd_data)), exp_y(k));
            chk({nm, "_y_literal"}, int'($signed(rd_data)), lit[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int e0;
        ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; rd_addr = '0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid_x", int'(m_valid_x), 0);
        chk("rst_valid_f", int'(m_valid_f), 0);
        chk("rst_ready_y", int'(s_ready_y), 0);
        chk("rst_data_x", int'(m_data_x), 0);
        chk("rst_data_f", int'(m_data_f), 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;

        // Job 1: X = 1..8, F = 1,1,1,1; X[0] written in the start cycle
        for (int i = 1; i < XS; i++) load(1'b0, i, i + 1);
        for (int i = 0; i < FS; i++) load(1'b1, i, 1);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = 8'd1; mx[0] = 1;
        start = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        start = 1'b0;
        #4;
        chk("t1_valid_x_rise", int'(m_valid_x), 1);
        chk("t1_valid_f_rise", int'(m_valid_f), 1);
        wait_done("t1");
        check_results("t1", lit1);

        // Job 2: F = -1,2,0,3 with stalling readies
        load(1'b1, 0, -1);
        load(1'b1, 1, 2);
        load(1'b1, 2, 0);
        load(1'b1, 3, 3);
        rdy_mode = 1;
        start_job();
        wait_done("t2");
        check_results("t2", lit2);

        // Job 3: y valid held past the last accepted beat
        rdy_mode = 0;
        extra_y  = 1'b1;
        e0 = extra_seen;
        start_job();
        wait_done("t3");
        extra_y = 1'b0;
        chk("t3_extra_beat_offered", int'(extra_seen > e0), 1);
        check_results("t3", lit2);

        // Job 4: start mid-STREAM and host writes during DRAIN are ignored
        y_gate = 1'b0;
        start_job();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(xi == XS && fi == FS) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_streams_complete", int'(xi == XS && fi == FS), 1);
        @(negedge clk);
        #4;
        chk("t4_drain_busy", int'(busy), 1);
        chk("t4_drain_no_x_valid", int'(m_valid_x), 0);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = 8'h5A;
        @(negedge clk);
        ld_sel = 1'b1; ld_addr = 3'd1;
        @(negedge clk);
        ld_en  = 1'b0;
        y_gate = 1'b1;
        wait_done("t4");
        check_results("t4", lit2);

        // Job 5: reset after 3 X beats, then replay from index 0
        start_job();
        n = 0;
        while (xi < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_x_beats_before_reset", xi, 3);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_valid_x", int'(m_valid_x), 0);
        chk("t5_rst_valid_f", int'(m_valid_f), 0);
        chk("t5_rst_ready_y", int'(s_ready_y), 0);
        chk("t5_rst_data_x", int'(m_data_x), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        start_job();
        wait_done("t5");
        check_results("t5", lit2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
